hpdcache_cmo_dir: RTL and testbench
===================================

HPDCACHE_CMO_DIR -- requirements
Module: hpdcache_cmo_dir

Interface
REQ-001 The block SHALL have parameter SETS, default 64, number of directory sets (power of two, >=2).
REQ-002 The block SHALL have parameter WAYS, default 4, number of ways.
REQ-003 The block SHALL have parameter TAG_WIDTH, default 20, tag bits per entry.
REQ-004 The block SHALL have port clk_i  in  1  clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port init_done_o  out  1  high once the initialization sweep has completed.
REQ-007 The block SHALL have port dir_check_i  in  1  check request.
REQ-008 The block SHALL have port dir_check_set_i  in  log2(SETS)  set to check.
REQ-009 The block SHALL have port dir_check_tag_i  in  TAG_WIDTH  tag to compare.
REQ-010 The block SHALL have port dir_check_hit_way_o  out  WAYS  per-way hit vector of the last check.
REQ-011 The block SHALL have port dir_inval_i  in  1  invalidate request.
REQ-012 The block SHALL have port dir_inval_set_i  in  log2(SETS)  set to invalidate.
REQ-013 The block SHALL have port dir_inval_way_i  in  WAYS  ways to invalidate (any mask).
REQ-014 The block SHALL have port refill_i  in  1  line-install request.
REQ-015 The block SHALL have port refill_set_i  in  log2(SETS)  refill set.
REQ-016 The block SHALL have port refill_way_i  in  WAYS  refill way mask.
REQ-017 The block SHALL have port refill_tag_i  in  TAG_WIDTH  refill tag.

Function
REQ-018 Storage SHALL be a valid bit and a TAG_WIDTH tag per (set, way); valid and tag arrays are not reset.
REQ-019 The FSM SHALL have states INIT and READY; reset enters INIT with sweep counter 0.
REQ-020 In INIT, each cycle SHALL clear all valid bits of set sweep counter, then increment it; after clearing set SETS-1 the FSM moves to READY (exactly SETS cycles after reset release).
REQ-021 init_done_o SHALL equal (state == READY).
REQ-022 In INIT, check, inval and refill requests SHALL be ignored; dir_check_hit_way_o SHALL be 0.
REQ-023 In READY, a check at cycle N SHALL drive dir_check_hit_way_o at N+1 with bit w = valid[set][w] AND tag[set][w]==tag, evaluated on the state before any update made in cycle N.
REQ-024 dir_check_hit_way_o SHALL be registered and SHALL hold its value until the next accepted check.
REQ-025 An inval at cycle N SHALL clear valid[set][w] for every w set in dir_inval_way_i, visible from N+1; an all-zero mask is a no-op.
REQ-026 A refill at cycle N SHALL, for every w set in refill_way_i, write the tag and set valid, visible from N+1.
REQ-027 Inval and refill to the same (set, way) in the same cycle SHALL leave the entry invalid (inval wins); to different entries both take effect.
REQ-028 Check, inval and refill in the same cycle SHALL all be accepted; there is no back-pressure.

Reset
REQ-029 On rst_ni low: state INIT, sweep counter 0, dir_check_hit_way_o 0, init_done_o 0 (and inval_cnt_o 0 when configured).
REQ-030 Reset asserted mid-sweep or mid-operation SHALL restart the full SETS-cycle sweep, discarding all directory contents.

Configuration
REQ-031 Macro HPDCACHE_DIR_INVAL_CNT_EN defined SHALL add output port inval_cnt_o (16 bits), counting entries transitioning valid->invalid via dir_inval_i, incremented by the popcount of the affected ways, saturating at 0xFFFF.
REQ-032 inval_cnt_o SHALL NOT count sweep clears or invalidating already-invalid entries.
REQ-033 Without HPDCACHE_DIR_INVAL_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Release reset, SETS=64 -> init_done_o rises exactly 64 cycles later; checks issued meanwhile return 0.
REQ-035 Refill set 5 way 0b0010 tag 0xABCDE, then check set 5 tag 0xABCDE -> hit 0b0010 one cycle after the check; tag 0xABCDF -> 0b0000.
REQ-036 Refill all 4 ways of set 3, then inval set 3 mask 0b0101, then check -> hit 0b1010; inval_cnt_o increments by 2 when configured.
REQ-037 Same-cycle refill and inval to set 7 way 0b0001, then check -> 0b0000; same-cycle check at set 7 returns the pre-update state.
REQ-038 Reset asserted at sweep cycle 30 after refills -> sweep restarts, init_done_o after 64 more cycles, all checks miss.
REQ-039 With HPDCACHE_DIR_INVAL_CNT_EN, preload counter near 0xFFFF and invalidate 4 valid ways -> inval_cnt_o saturates at 0xFFFF.

Source files
------------

// File: rtl/hpdcache_cmo_dir.sv
// Cache-maintenance tag directory: valid/tag storage with an init sweep, check, invalidate and refill ports.
// Optional macro HPDCACHE_DIR_INVAL_CNT_EN adds a saturating valid->invalid counter on inval_cnt_o.
module hpdcache_cmo_dir #(
    parameter int unsigned SETS      = 64,
    parameter int unsigned WAYS      = 4,
    parameter int unsigned TAG_WIDTH = 20
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    init_done_o,
    input  logic                    dir_check_i,
    input  logic [$clog2(SETS)-1:0] dir_check_set_i,
    input  logic [TAG_WIDTH-1:0]    dir_check_tag_i,
    output logic [WAYS-1:0]         dir_check_hit_way_o,
    input  logic                    dir_inval_i,
    input  logic [$clog2(SETS)-1:0] dir_inval_set_i,
    input  logic [WAYS-1:0]         dir_inval_way_i,
    input  logic                    refill_i,
    input  logic [$clog2(SETS)-1:0] refill_set_i,
    input  logic [WAYS-1:0]         refill_way_i,
    input  logic [TAG_WIDTH-1:0]    refill_tag_i
`ifdef HPDCACHE_DIR_INVAL_CNT_EN
    ,
    output logic [15:0]             inval_cnt_o
`endif
);

    localparam int unsigned SET_W = $clog2(SETS);
    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

    typedef enum logic {
        INIT,
        READY
    } state_e;

    state_e                 state_q, state_d;
    logic [SET_W-1:0]       sweep_q, sweep_d;
    logic [WAYS-1:0]        hit_q, hit_d;

    logic [WAYS-1:0]        valid_q [SETS];
    logic [TAG_WIDTH-1:0]   tag_q   [SETS][WAYS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
            sweep_q <= '0;
            hit_q   <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        hit_d   = hit_q;
        case (state_q)
            INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_SET) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (dir_check_i) begin
                    for (int w = 0; w < WAYS; w++) begin
                        hit_d[w] = valid_q[dir_check_set_i][w] &&
                                   (tag_q[dir_check_set_i][w] == dir_check_tag_i);
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    // Storage is never reset; the sweep clears it. Inval is written last so it wins over refill.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            valid_q[sweep_q] <= '0;
        end else begin
            for (int w = 0; w < WAYS; w++) begin
                if (refill_i && refill_way_i[w]) begin
                    valid_q[refill_set_i][w] <= 1'b1;
                    tag_q[refill_set_i][w]   <= refill_tag_i;
                end
            end
            for (int w = 0; w < WAYS; w++) begin
                if (dir_inval_i && dir_inval_way_i[w]) begin
                    valid_q[dir_inval_set_i][w] <= 1'b0;
                end
            end
        end
    end

    assign init_done_o         = (state_q == READY);
    assign dir_check_hit_way_o = hit_q;

`ifdef HPDCACHE_DIR_INVAL_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [16:0] cnt_sum;

    // Only entries valid before this cycle count, even if a refill targets them too.
    always_comb begin
        cnt_sum = {1'b0, cnt_q};
        if ((state_q == READY) && dir_inval_i) begin
            for (int w = 0; w < WAYS; w++) begin
                cnt_sum = cnt_sum + 17'(valid_q[dir_inval_set_i][w] & dir_inval_way_i[w]);
            end
        end
        cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign inval_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_hpdcache_cmo_dir.sv
// Scoreboard bench for hpdcache_cmo_dir: a set/way array model predicts check results,
// init timing and (with HPDCACHE_DIR_INVAL_CNT_EN) the invalidation counter.
module tb_hpdcache_cmo_dir;

    localparam int SETS = 64;
    localparam int WAYS = 4;
    localparam int TW   = 20;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          init_done_o;
    logic          dir_check_i = 1'b0;
    logic [5:0]    dir_check_set_i = '0;
    logic [TW-1:0] dir_check_tag_i = '0;
    logic [3:0]    dir_check_hit_way_o;
    logic          dir_inval_i = 1'b0;
    logic [5:0]    dir_inval_set_i = '0;
    logic [3:0]    dir_inval_way_i = '0;
    logic          refill_i = 1'b0;
    logic [5:0]    refill_set_i = '0;
    logic [3:0]    refill_way_i = '0;
    logic [TW-1:0] refill_tag_i = '0;
`ifdef HPDCACHE_DIR_INVAL_CNT_EN
    logic [15:0]   inval_cnt_o;
`endif

    hpdcache_cmo_dir #(.SETS(SETS), .WAYS(WAYS), .TAG_WIDTH(TW)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .init_done_o         (init_done_o),
        .dir_check_i         (dir_check_i),
        .dir_check_set_i     (dir_check_set_i),
        .dir_check_tag_i     (dir_check_tag_i),
        .dir_check_hit_way_o (dir_check_hit_way_o),
        .dir_inval_i         (dir_inval_i),
        .dir_inval_set_i     (dir_inval_set_i),
        .dir_inval_way_i     (dir_inval_way_i),
        .refill_i            (refill_i),
        .refill_set_i        (refill_set_i),
        .refill_way_i        (refill_way_i),
        .refill_tag_i        (refill_tag_i)
`ifdef HPDCACHE_DIR_INVAL_CNT_EN
        ,
        .inval_cnt_o         (inval_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // Reference model: plain arrays of what each entry holds, plus init progress.
    bit          mValid [SETS][WAYS];
    logic [TW-1:0] mTag [SETS][WAYS];
    bit          dutReady = 1'b0;
    int          sweepCnt = 0;
    int          expCnt = 0;

    logic [3:0]  expQ [$];
    logic [3:0]  expHold = '0;
    logic        chkPend = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;

    // A check accepted on an edge has its response visible from that edge on.
    always @(posedge clk_i) chkPend <= dir_check_i && rst_ni;

    // Monitor: pops an expectation whenever a response was produced, otherwise the output must hold.
    always @(negedge clk_i) begin
        if (chkPend) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL hit_pop: response produced but no expectation queued at %0t", $time);
            end else begin
                expHold = expQ.pop_front();
            end
        end
        if (!rst_ni) expHold = '0;
        vectors++;
        if (dir_check_hit_way_o !== expHold) begin
            miscompares++;
            $display("[TB] FAIL hit_way: got %b expected %b at %0t", dir_check_hit_way_o, expHold, $time);
        end
        vectors++;
        if (init_done_o !== dutReady) begin
            miscompares++;
            $display("[TB] FAIL init_done: got %b expected %b at %0t", init_done_o, dutReady, $time);
        end
`ifdef HPDCACHE_DIR_INVAL_CNT_EN
        vectors++;
        if (inval_cnt_o !== 16'(expCnt)) begin
            miscompares++;
            $display("[TB] FAIL inval_cnt: got %h expected %h at %0t", inval_cnt_o, 16'(expCnt), $time);
        end
`endif
    end

    // One cycle of stimulus; expected check result comes from the model's pre-edge contents.
    task automatic applyStimulus(input logic chk, input logic [5:0] cset, input logic [TW-1:0] ctag,
                                 input logic inv, input logic [5:0] iset, input logic [3:0] imask,
                                 input logic rf, input logic [5:0] rset, input logic [3:0] rmask,
                                 input logic [TW-1:0] rtag);
        logic [3:0] exp;
        int n;
        dir_check_i = chk;  dir_check_set_i = cset; dir_check_tag_i = ctag;
        dir_inval_i = inv;  dir_inval_set_i = iset; dir_inval_way_i = imask;
        refill_i    = rf;   refill_set_i    = rset; refill_way_i    = rmask; refill_tag_i = rtag;
        if (chk) begin
            exp = '0;
            if (dutReady)
                for (int w = 0; w < WAYS; w++) exp[w] = mValid[cset][w] && (mTag[cset][w] == ctag);
            expQ.push_back(exp);
        end
        @(posedge clk_i);
        #1;
        if (dutReady) begin
            n = 0;
            if (inv) for (int w = 0; w < WAYS; w++) if (imask[w] && mValid[iset][w]) n++;
            if (rf) for (int w = 0; w < WAYS; w++) if (rmask[w]) begin
                mValid[rset][w] = 1'b1;
                mTag[rset][w]   = rtag;
            end
            if (inv) for (int w = 0; w < WAYS; w++) if (imask[w]) mValid[iset][w] = 1'b0;
            expCnt = (expCnt + n > 65535) ? 65535 : expCnt + n;
        end else begin
            sweepCnt++;
            if (sweepCnt == SETS) dutReady = 1'b1;
        end
        dir_check_i = 1'b0;
        dir_inval_i = 1'b0;
        refill_i    = 1'b0;
    endtask

    task automatic idle(input int cycles, input logic withChecks);
        for (int i = 0; i < cycles; i++)
            applyStimulus(withChecks, 6'($urandom_range(0, 7)), TW'($urandom), 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        rst_ni = 1'b0;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) mValid[s][w] = 1'b0;
        dutReady = 1'b0;
        sweepCnt = 0;
        expCnt   = 0;
        repeat (2) begin
            @(posedge clk_i);
            #1;
        end
        rst_ni = 1'b1;
    endtask

    task automatic checkOutput(input logic [5:0] cset, input logic [TW-1:0] ctag);
        applyStimulus(1, cset, ctag, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        doReset();
        // Sweep: init_done must rise exactly SETS cycles after release; checks meanwhile return 0.
        idle(SETS, 1'b1);
        idle(2, 1'b0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6'd5, 4'b0010, 20'hABCDE);
        checkOutput(6'd5, 20'hABCDE);
        checkOutput(6'd5, 20'hABCDF);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6'd3, 4'b1111, 20'h12345);
        applyStimulus(0, 0, 0, 1, 6'd3, 4'b0101, 0, 0, 0, 0);
        checkOutput(6'd3, 20'h12345);
        applyStimulus(0, 0, 0, 1, 6'd3, 4'b0000, 0, 0, 0, 0);
        checkOutput(6'd3, 20'h12345);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 6'd7, 4'b0001, 20'h00777);
        applyStimulus(1, 6'd7, 20'h00777, 1, 6'd7, 4'b0001, 1, 6'd7, 4'b0011, 20'h00777);
        checkOutput(6'd7, 20'h00777);
        idle(3, 1'b0);

        // Randomized traffic over a few sets and tags so hits and collisions are frequent.
        for (int i = 0; i < 400; i++)
            applyStimulus(1'($urandom), 6'($urandom_range(0, 3)), TW'($urandom_range(0, 3)),
                          1'($urandom_range(0, 2) == 0), 6'($urandom_range(0, 3)), 4'($urandom),
                          1'($urandom), 6'($urandom_range(0, 3)), 4'($urandom), TW'($urandom_range(0, 3)));
        idle(2, 1'b0);

        // Reset in mid-sweep after refills: everything must be gone after the restarted sweep.
        for (int s = 0; s < 4; s++)
            applyStimulus(0, 0, 0, 0, 0, 0, 1, 6'(s + 20), 4'b1111, 20'h0BEEF);
        doReset();
        idle(30, 1'b0);
        doReset();
        idle(SETS, 1'b1);
        for (int s = 0; s < 4; s++) checkOutput(6'(s + 20), 20'h0BEEF);
        idle(2, 1'b0);

`ifdef HPDCACHE_DIR_INVAL_CNT_EN
        // Ping-pong two sets to drive the counter into saturation.
        for (int i = 0; i < 16400; i++)
            applyStimulus(0, 0, 0, 1, (i % 2) ? 6'd10 : 6'd11, 4'hF,
                          1, (i % 2) ? 6'd11 : 6'd10, 4'hF, 20'h00123);
        idle(2, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
